// File: rtl/wb_reg_writer.sv
// Write-back register-file writer: merges non-stallable ALU results with
// buffered load results, suppresses x0 writes and kills stale loads that a
// younger ALU write to the same register supersedes.
module wb_reg_writer #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned REG_NUM      = 5,
  parameter int unsigned COMMON_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [REG_NUM-1:0]          alu_rd,
  input  logic [COMMON_WIDTH-1:0]     alu_data,
  input  logic                        mem_valid,
  input  logic [REG_NUM-1:0]          mem_rd,
  input  logic [COMMON_WIDTH-1:0]     mem_data,
  output logic                        mem_ready,
  output logic [REG_NUM-1:0]          reg_write,
  output logic [COMMON_WIDTH-1:0]     data_write,
  output logic [$clog2(FIFO_DEPTH):0] wb_pending
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [REG_NUM-1:0]      rd_q  [FIFO_DEPTH];
  logic [REG_NUM-1:0]      rd_d  [FIFO_DEPTH];
  logic [COMMON_WIDTH-1:0] dat_q [FIFO_DEPTH];
  logic [COMMON_WIDTH-1:0] dat_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   live_q, live_d;
  logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d, pend_q, pend_d;
  logic [REG_NUM-1:0]      reg_write_q, reg_write_d;
  logic [COMMON_WIDTH-1:0] data_write_q, data_write_d;

  logic alu_eff, mem_eff, fifo_empty, pop, bypass, push, xfer;

  // Handshake and source selection decisions for this cycle
  always_comb begin
    alu_eff    = alu_valid && (alu_rd != '0);
    fifo_empty = (count_q == '0);
    pop        = !alu_eff && !fifo_empty;
    mem_ready  = rst && ((count_q < CNT_W'(FIFO_DEPTH)) || pop);
    xfer       = mem_valid && mem_ready;
    mem_eff    = xfer && (mem_rd != '0);
    bypass     = mem_eff && !alu_eff && fifo_empty;
    push       = mem_eff && !bypass;
  end

  // FIFO next state: pop, kill, push, then count live entries
  always_comb begin
    rd_d    = rd_q;
    dat_d   = dat_q;
    live_d  = live_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    pend_d  = '0;
    // Popped slots have live cleared, so free slots never count as pending.
    if (pop) begin
      live_d[head_q] = 1'b0;
      head_d         = head_q + PTR_W'(1);
    end
    if (alu_eff) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (rd_q[i[PTR_W-1:0]] == alu_rd) live_d[i[PTR_W-1:0]] = 1'b0;
      end
    end
    // A same-cycle load to the ALU's register is stored already killed.
    if (push) begin
      rd_d[tail_q]   = mem_rd;
      dat_d[tail_q]  = mem_data;
      live_d[tail_q] = !(alu_eff && (mem_rd == alu_rd));
      tail_d         = tail_q + PTR_W'(1);
    end
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      pend_d = pend_d + CNT_W'(live_d[i[PTR_W-1:0]]);
    end
  end

  // Output register source: ALU, then FIFO head, then load bypass
  always_comb begin
    reg_write_d  = '0;
    data_write_d = data_write_q;
    if (alu_eff) begin
      reg_write_d  = alu_rd;
      data_write_d = alu_data;
    end else if (pop) begin
      if (live_q[head_q]) begin
        reg_write_d  = rd_q[head_q];
        data_write_d = dat_q[head_q];
      end
    end else if (bypass) begin
      reg_write_d  = mem_rd;
      data_write_d = mem_data;
    end
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      live_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      pend_q       <= '0;
      reg_write_q  <= '0;
      data_write_q <= '0;
    end else begin
      live_q       <= live_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      pend_q       <= pend_d;
      reg_write_q  <= reg_write_d;
      data_write_q <= data_write_d;
    end
  end

  // Entry payload storage; validity is tracked by count/live only
  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    dat_q <= dat_d;
  end

  assign reg_write  = reg_write_q;
  assign data_write = data_write_q;
  assign wb_pending = pend_q;

endmodule
